// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i core: arbiter FSM states, grant encodings, XLEN.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Port identifiers recorded in last_gnt
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Each level-held request becomes one registered memory command, completes
// with a one-cycle *_valid pulse, and stall freezes the core meanwhile.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W = XLEN,
    parameter int unsigned DATA_W = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_valid,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  stall
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_t          r_state;
    logic                r_last_gnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_if_valid;
    logic                r_dm_valid;

    logic                w_any_req;
    logic                w_gnt_dm;

    // Round-robin pick: on a conflict the port not served last time wins
    always_comb begin
        w_any_req = if_req | dm_req;
        w_gnt_dm  = dm_req & (~if_req | (r_last_gnt == GNT_IF));
    end

    // Arbiter FSM: latch command on grant, wait for mem_ready, pulse valid once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last_gnt  <= GNT_IF;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state    <= BUSY;
                        r_mem_req  <= 1'b1;
                        r_last_gnt <= w_gnt_dm ? GNT_DM : GNT_IF;
                        if (w_gnt_dm) begin
                            r_mem_we    <= dm_we;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                            r_mem_be    <= dm_be;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                            r_mem_be    <= '1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_last_gnt == GNT_DM) begin
                            // A store returns zero rather than whatever the bus carried
                            r_dm_rdata <= r_mem_we ? '0 : mem_rdata;
                            r_dm_valid <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    r_if_valid <= 1'b0;
                    r_dm_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_req  <= 1'b0;
                    r_if_valid <= 1'b0;
                    r_dm_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output wiring; stall covers every requester not yet answered this cycle
    always_comb begin
        mem_req   = r_mem_req;
        mem_we    = r_mem_we;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        mem_be    = r_mem_be;
        if_rdata  = r_if_rdata;
        dm_rdata  = r_dm_rdata;
        if_valid  = r_if_valid;
        dm_valid  = r_dm_valid;
        stall     = (if_req & ~r_if_valid) | (dm_req & ~r_dm_valid);
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: table of transactions plus hand-written
// sequences for idle mem_ready, late address changes and mid-transaction reset.
module tb_rv32i_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;

    always #5 clk = ~clk;

    rv32i_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    typedef struct {
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_be;
        int unsigned waits;
        logic [31:0] rdata;
        logic        exp_dm;
        logic        drop;
    } vec_t;

    vec_t        vecs[10];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic we,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic [3:0] be,
                                input int unsigned w, input logic [31:0] rd,
                                input logic edm, input logic drp);
        vec_t v;
        v.if_req = ir;  v.dm_req = dr;  v.dm_we = we;
        v.if_addr = ia; v.dm_addr = da; v.dm_wdata = wd; v.dm_be = be;
        v.waits = w;    v.rdata = rd;   v.exp_dm = edm;  v.drop = drp;
        return v;
    endfunction

    // Starts in IDLE, ends one cycle after the valid pulse (IDLE again)
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        if_req   = v.if_req;
        dm_req   = v.dm_req;
        dm_we    = v.dm_we;
        if_addr  = v.if_addr;
        dm_addr  = v.dm_addr;
        dm_wdata = v.dm_wdata;
        dm_be    = v.dm_be;
        #1;
        chk($sformatf("v%0d stall_req", idx), {31'b0, stall}, 32'd1);
        step();
        e_addr = v.exp_dm ? v.dm_addr : v.if_addr;
        e_we   = v.exp_dm ? v.dm_we : 1'b0;
        e_be   = v.exp_dm ? v.dm_be : 4'hF;
        for (int i = 0; i <= int'(v.waits); i++) begin
            chk($sformatf("v%0d mem_req c%0d", idx, i + 1), {31'b0, mem_req}, 32'd1);
            chk($sformatf("v%0d mem_addr c%0d", idx, i + 1), mem_addr, e_addr);
            chk($sformatf("v%0d mem_we c%0d", idx, i + 1), {31'b0, mem_we}, {31'b0, e_we});
            chk($sformatf("v%0d mem_be c%0d", idx, i + 1), {28'b0, mem_be}, {28'b0, e_be});
            if (v.exp_dm)
                chk($sformatf("v%0d mem_wdata c%0d", idx, i + 1), mem_wdata, v.dm_wdata);
            chk($sformatf("v%0d stall_busy c%0d", idx, i + 1), {31'b0, stall}, 32'd1);
            chk($sformatf("v%0d valid_busy c%0d", idx, i + 1),
                {30'b0, if_valid, dm_valid}, 32'd0);
            mem_ready = (i == int'(v.waits));
            mem_rdata = mem_ready ? v.rdata : (32'hBAD0_0000 | i);
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (v.exp_dm) exp_dm_rdata = v.dm_we ? 32'd0 : v.rdata;
        else          exp_if_rdata = v.rdata;
        chk($sformatf("v%0d if_valid", idx), {31'b0, if_valid}, {31'b0, !v.exp_dm});
        chk($sformatf("v%0d dm_valid", idx), {31'b0, dm_valid}, {31'b0, v.exp_dm});
        chk($sformatf("v%0d if_rdata", idx), if_rdata, exp_if_rdata);
        chk($sformatf("v%0d dm_rdata", idx), dm_rdata, exp_dm_rdata);
        chk($sformatf("v%0d mem_req_resp", idx), {31'b0, mem_req}, 32'd0);
        // The losing port, if still requesting, keeps stall high
        chk($sformatf("v%0d stall_resp", idx), {31'b0, stall},
            {31'b0, (v.if_req & v.exp_dm) | (v.dm_req & !v.exp_dm)});
        if (v.drop) begin
            if_req = 1'b0;
            dm_req = 1'b0;
        end
        step();
        chk($sformatf("v%0d valid_clear", idx), {30'b0, if_valid, dm_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        //             ir    dr    we    if_addr       dm_addr       wdata          be     w  rdata          edm   drop
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h0,         4'h0, 0, 32'h0050_0093, 1'b0, 1'b1);
        vecs[1] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0200, 32'h0,        4'hF, 0, 32'hA1A1_0001, 1'b1, 1'b0);
        vecs[2] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0200, 32'h0,        4'hF, 1, 32'h0000_0113, 1'b0, 1'b0);
        vecs[3] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0200, 32'h0,        4'hF, 0, 32'hA1A1_0003, 1'b1, 1'b0);
        vecs[4] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0200, 32'h0,        4'hF, 2, 32'h0000_0213, 1'b0, 1'b0);
        vecs[5] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0200, 32'h0,        4'hF, 0, 32'hA1A1_0005, 1'b1, 1'b0);
        vecs[6] = mk(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0200, 32'h0,        4'hF, 1, 32'h0000_0313, 1'b0, 1'b1);
        vecs[7] = mk(1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 3, 32'hFFFF_FFFF, 1'b1, 1'b1);
        vecs[8] = mk(1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0,        32'h0,         4'h0, 1, 32'h0020_8133, 1'b0, 1'b1);
        vecs[9] = mk(1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0104, 32'h0,        4'hF, 2, 32'h1234_ABCD, 1'b1, 1'b1);

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst mem_cmd", mem_addr | mem_wdata | {28'b0, mem_be} | {31'b0, mem_we}, 32'd0);
        chk("rst valids", {30'b0, if_valid, dm_valid}, 32'd0);
        chk("rst rdata", if_rdata | dm_rdata, 32'd0);
        chk("rst stall", {31'b0, stall}, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_rst mem_req", {31'b0, mem_req}, 32'd0);

        for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

        // mem_ready with no request outstanding must be ignored
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("idle_ready mem_req", {31'b0, mem_req}, 32'd0);
            chk("idle_ready valids", {30'b0, if_valid, dm_valid}, 32'd0);
            chk("idle_ready if_rdata", if_rdata, exp_if_rdata);
        end
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Address change after grant does not reach the memory command
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        step();
        chk("late_addr c1", mem_addr, 32'h0000_0040);
        if_addr = 32'h0000_0044;
        step();
        chk("late_addr c2", mem_addr, 32'h0000_0040);
        mem_ready = 1'b1;
        mem_rdata = 32'h0041_0113;
        step();
        mem_ready = 1'b0;
        chk("late_addr if_valid", {31'b0, if_valid}, 32'd1);
        chk("late_addr if_rdata", if_rdata, 32'h0041_0113);
        if_req = 1'b0;
        step();

        // Reset during a load's wait states aborts it
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0300;
        dm_be   = 4'hF;
        step();
        chk("abort mem_req c1", {31'b0, mem_req}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        chk("abort mem_req async", {31'b0, mem_req}, 32'd0);
        chk("abort rdata cleared", if_rdata | dm_rdata, 32'd0);
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        dm_req = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b1;
            step();
            chk("abort no_valid", {30'b0, if_valid, dm_valid}, 32'd0);
            chk("abort idle mem_req", {31'b0, mem_req}, 32'd0);
        end
        mem_ready = 1'b0;

        // First conflict after reset goes to the data port
        if_req  = 1'b1;
        if_addr = 32'h0000_0050;
        dm_req  = 1'b1;
        dm_addr = 32'h0000_0500;
        step();
        chk("post_abort grant addr", mem_addr, 32'h0000_0500);
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_0001;
        step();
        mem_ready = 1'b0;
        chk("post_abort dm_valid", {31'b0, dm_valid}, 32'd1);
        chk("post_abort dm_rdata", dm_rdata, 32'h7777_0001);
        if_req = 1'b0;
        dm_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Arbiter and sequencer that shares one single-port memory between the RV32I instruction-fetch path and the load/store path of the datapath. It turns two level-held requests into serialized memory transactions with a req/ready handshake, returns one-cycle response pulses to each requester, and drives a stall signal that freezes the PC and register file while either access is outstanding. It sits between the `rv32i` core top and the unified memory model.

## Interface
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req` is high
- `if_rdata`  out  DATA_W  fetched word, valid with `if_valid`
- `if_valid`  out  1  one-cycle fetch completion pulse
- `dm_req`  in  1  data request, level
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_be`  in  DATA_W/8  store byte enables, passed through unchanged
- `dm_rdata`  out  DATA_W  load data; 0 after a store
- `dm_valid`  out  1  one-cycle data completion pulse
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  registered command
- `mem_ready`  in  1  memory completion, sampled only while `mem_req` is high
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ready`
- `stall`  out  1  combinational: `(if_req & ~if_valid) | (dm_req & ~dm_valid)`

## Operation
- FSM states: IDLE, BUSY, RESP. Register `last_gnt` records the last granted port (IF or DM).
- IDLE: if neither request is high, stay. If exactly one is high, grant it. If both are high, grant the port that is not `last_gnt`.
- On grant: register the command into the `mem_*` outputs. A fetch grant drives `mem_we=0` and `mem_be` all-ones. Set `mem_req=1`, update `last_gnt`, go to BUSY.
- BUSY: hold the `mem_*` outputs stable. When `mem_ready=1`:
  - capture `mem_rdata` into the granted port's rdata register (`dm_rdata` is 0 for a store);
  - clear `mem_req`;
  - go to RESP.
- RESP: assert the granted port's `*_valid` for exactly one cycle. Requests are ignored in this state. Return to IDLE.
- A request still high in IDLE after its `*_valid` cycle counts as a new transaction, so back-to-back accesses are allowed. A requester that wants a single access must drop `req` by the cycle after `valid`.
- Changing `*_addr`, `*_wdata`, `dm_we` or `dm_be` while `req` is high has no effect once the request is granted (the command is registered).
- `*_rdata` holds its last value outside `*_valid` cycles.

## Timing
- Reset (async, `reset=0`): state IDLE, `last_gnt`=IF (so the first conflict goes to DM), all outputs 0. `stall` follows its equation.
- Reset asserted mid-transaction: abort immediately, drop `mem_req`, emit no `*_valid`. The memory must tolerate an abandoned request.
- Zero-wait memory (`mem_ready` high in the first `mem_req` cycle):
  - `req` sampled in cycle 0;
  - `mem_req` high in cycle 1;
  - `*_valid` in cycle 2;
  - next grant sampled in cycle 3.
- N wait states: `*_valid` in cycle 2+N. Peak throughput is one transaction per 3 cycles.
- Both requests held continuously: grants alternate DM, IF, DM, … Neither port starves.
- `mem_ready` while `mem_req=0` is ignored.

## Structure
- Shared package `rv32i_pkg`:
  - state enum `arb_state_t` {IDLE, BUSY, RESP};
  - grant constants `GNT_IF`, `GNT_DM`;
  - `XLEN=32` (the default for both parameters).
- Single module, no sub-module. The round-robin decision is two lines inside the FSM.
- `rv32i` instantiates this block. `stall` gates the PC and `RegWrite` enables in `Datapath`.

## Test plan
- Reset, then `if_req=1`, `if_addr=0x00000010`, memory returns `0x00500093` with 0 wait states -> `mem_req` in cycle 1 with `mem_addr=0x10`; `if_valid` in cycle 2 with `if_rdata=0x00500093`; `stall` high in cycles 0-1, low in cycle 2.
- Fetch and load requested together from IDLE after reset -> DM granted first. Next grant goes to IF. Continuous requests alternate DM/IF for 6 transactions.
- Store `dm_addr=0x100`, `dm_wdata=0xDEADBEEF`, `dm_be=4'b0011`, 3 wait states -> `mem_we=1`, `mem_be=0011`, command stable for 4 cycles; `dm_valid` in cycle 5 with `dm_rdata=0`.
- Load with 2 wait states, `reset` pulsed low during BUSY -> `mem_req` drops asynchronously; no `dm_valid`; state IDLE after release.
- `mem_ready` pulsed while IDLE with no requests -> no state change, no valid pulse. Then `if_addr` changed after grant -> `mem_addr` keeps the granted value.
